line_clear_scanner: RTL and testbench
=====================================

# line_clear_scanner

Upstream stage of the scoring path. After the active piece locks, this block scans the playfield row memory bottom-to-top and detects full rows. It compacts the board in place by dropping the surviving rows down over the cleared ones and zero-filling the top. It then emits a one-cycle `hit` together with the 2-bit `lineCount` that the hit-time stretcher and score logic consume.

## Interface
- `WIDTH`, 10, cells per row (bits of a row word)
- `HEIGHT`, 20, rows in the playfield; row 0 = top, row HEIGHT-1 = bottom
- `AW`, 5, row address width (must satisfy 2^AW >= HEIGHT)

- `clk`  in  1  single system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request: piece has locked, begin scan
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the board update is finished
- `hit`  out  1  one-cycle pulse, coincident with `done`, only if ≥1 row was cleared
- `lineCount`  out  2  cleared rows, saturated at 3; valid while `hit`=1, 0 otherwise
- `clear_count`  out  3  raw cleared-row count (0..4), held from `done` until the next accepted `start`
- `row_addr`  out  AW  shared read/write row address to the board memory
- `row_we`  out  1  write strobe for `row_addr`/`row_wdata`
- `row_wdata`  out  WIDTH  row word to write
- `row_rdata`  in  WIDTH  read data; synchronous memory, valid one cycle after `row_addr` is presented with `row_we`=0

## Operation
- Registers: read pointer `r`, write pointer `w` (AW bits each), count `cnt` (3 bits), state.
- IDLE: `busy`=0. When `start`=1, load `r`=`w`=HEIGHT-1 and `cnt`=0, then go to RD.
- RD: drive `row_addr`=`r` with `row_we`=0, then go to EV.
- EV: `row_rdata` is valid in this cycle.
  - Row full (all WIDTH bits 1): `cnt`++, no write.
  - Otherwise: `row_we`=1, `row_addr`=`w`, `row_wdata`=`row_rdata`, `w`--. This write is performed even when `w`==`r`.
  - If `r`==0: go to FILL when `cnt`>0, else go to FIN. Otherwise `r`-- and go to RD.
- FILL: `row_we`=1, `row_addr`=`w`, `row_wdata`=0.
  - If `w`==0, go to FIN; otherwise `w`-- and stay.
  - Exactly `cnt` zero rows are written, covering rows `cnt`-1..0.
- FIN: `done`=1 and `clear_count`=`cnt`.
  - If `cnt`>0: `hit`=1 and `lineCount`=min(`cnt`,3).
  - Next state is IDLE.
- `start` is ignored while `busy`=1 or in FIN. A `start` arriving in the cycle after FIN, i.e. back in IDLE, is accepted.
- Row-full test: reduction AND of `row_rdata`. `cnt` cannot exceed HEIGHT. It is 3 bits and saturates at 7; gameplay bounds it to 4.
- Reset (`rst_n`=0, any time, including mid-scan) forces:
  - IDLE;
  - `busy`=`done`=`hit`=`row_we`=0;
  - `lineCount`=0, `clear_count`=0, `row_addr`=0, `row_wdata`=0.
  
  A scan interrupted by reset leaves the board partially compacted; the game controller restarts the board after reset.

## Timing
- `busy` rises the cycle after `start` is sampled.
- Scan phase: 2·HEIGHT cycles (RD+EV per row).
- Fill phase: `cnt` cycles.
- Total from `start` sampled to the `done`/`hit` cycle: 2·HEIGHT + `cnt` + 1 cycles. With no clears: 41 cycles at HEIGHT=20.
- `done`, `hit` and `lineCount` are registered and high for exactly one cycle. `busy` is 0 in that cycle.
- `row_we` is never asserted in RD. Reads and writes never share a cycle.
- Writes only target row indices ≥ `r`, i.e. rows already read, so no unread row is overwritten.

## Test plan
- **Empty board:** `start`. Required: no writes change contents; `done` at cycle 41; `hit`=0; `lineCount`=0; `clear_count`=0.
- **Single clear:** row 19 = 0x3FF, row 18 = 0x001, rest 0. Required: afterwards row 19 = 0x001 and row 18 = 0; `hit`=1 with `lineCount`=1 at cycle 42; `clear_count`=1.
- **Interleaved clears:** rows 19 and 17 full, row 18 = 0x155, row 16 = 0x2AA. Required: row 19 = 0x155, row 18 = 0x2AA, rows 17..0 = 0; `lineCount`=2.
- **Tetris:** rows 19..16 full, row 15 = 0x00F. Required: row 19 = 0x00F, others 0; `clear_count`=4; `lineCount`=3 (saturated); `hit` pulse one cycle.
- **Start while busy:** `start` pulsed again at cycle 10 of a scan. Required: ignored; single `done`; a `start` in the first IDLE cycle after `done` begins a new scan.
- **Reset mid-scan:** `rst_n` low at cycle 15. Required: all outputs 0 immediately (asynchronous); after release, `busy`=0 until the next `start`, and a full scan then completes normally.

Source files
------------

// File: rtl/line_clear_scanner_if.sv
// Row-memory port between the line-clear scanner (master) and the playfield RAM (slave).
// The RAM returns row_rdata one cycle after a read address is presented.
interface line_clear_scanner_if #(
    parameter int WIDTH = 10,
    parameter int AW    = 5
);
    logic [AW-1:0]    row_addr;
    logic             row_we;
    logic [WIDTH-1:0] row_wdata;
    logic [WIDTH-1:0] row_rdata;

    modport master (
        output row_addr,
        output row_we,
        output row_wdata,
        input  row_rdata
    );

    modport slave (
        input  row_addr,
        input  row_we,
        input  row_wdata,
        output row_rdata
    );
endinterface

// File: rtl/line_clear_scanner.sv
// Scans the playfield bottom-to-top, drops surviving rows over full ones, zero-fills the top
// and reports the number of cleared rows with a one-cycle done/hit pulse.
module line_clear_scanner #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20,
    parameter int AW     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [1:0]  lineCount,
    output logic [2:0]  clear_count,
    line_clear_scanner_if.master mem
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_EV   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [AW-1:0] TOP_ROW  = AW'(HEIGHT - 1);
    localparam logic [AW-1:0] ROW_ZERO = {AW{1'b0}};

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    r_q, r_d;
    logic [AW-1:0]    w_q, w_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic [1:0]       line_count_q, line_count_d;
    logic [2:0]       clear_count_q, clear_count_d;

    logic [AW-1:0]    row_addr_s;
    logic             row_we_s;
    logic [WIDTH-1:0] row_wdata_s;
    logic             row_full_s;

    assign row_full_s = &mem.row_rdata;

    // Next-state logic plus the memory port; the EV write depends on the word read this cycle.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        row_addr_s  = {AW{1'b0}};
        row_we_s    = 1'b0;
        row_wdata_s = {WIDTH{1'b0}};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = TOP_ROW;
                    w_d     = TOP_ROW;
                    cnt_d   = 3'd0;
                    state_d = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                row_addr_s = r_q;
                state_d    = S_EV;
            end
            S_EV: begin
                if (row_full_s) begin
                    if (cnt_q != 3'd7) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    // Survivor is rewritten even when w == r so the datapath stays uniform.
                    row_we_s    = 1'b1;
                    row_addr_s  = w_q;
                    row_wdata_s = mem.row_rdata;
                    w_d         = w_q - {{(AW-1){1'b0}}, 1'b1};
                end
                if (r_q == ROW_ZERO) begin
                    if (cnt_d != 3'd0) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    r_d     = r_q - {{(AW-1){1'b0}}, 1'b1};
                    state_d = S_RD;
                end
            end
            S_FILL: begin
                row_we_s    = 1'b1;
                row_addr_s  = w_q;
                row_wdata_s = {WIDTH{1'b0}};
                if (w_q == ROW_ZERO) begin
                    state_d = S_FIN;
                end else begin
                    w_d     = w_q - {{(AW-1){1'b0}}, 1'b1};
                    state_d = S_FILL;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are computed from the upcoming state so they register in step with it.
    always_comb begin
        busy_d        = (state_d == S_RD) || (state_d == S_EV) || (state_d == S_FILL);
        done_d        = (state_d == S_FIN);
        hit_d         = (state_d == S_FIN) && (cnt_d != 3'd0);
        line_count_d  = 2'd0;
        clear_count_d = clear_count_q;
        if (hit_d) begin
            if (cnt_d > 3'd3) begin
                line_count_d = 2'd3;
            end else begin
                line_count_d = cnt_d[1:0];
            end
        end else begin
            line_count_d = 2'd0;
        end
        if (state_d == S_FIN) begin
            clear_count_d = cnt_d;
        end else if ((state_q == S_IDLE) && start) begin
            clear_count_d = 3'd0;
        end else begin
            clear_count_d = clear_count_q;
        end
    end

    // State, pointers and registered status flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            r_q           <= {AW{1'b0}};
            w_q           <= {AW{1'b0}};
            cnt_q         <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hit_q         <= 1'b0;
            line_count_q  <= 2'd0;
            clear_count_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            w_q           <= w_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            hit_q         <= hit_d;
            line_count_q  <= line_count_d;
            clear_count_q <= clear_count_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign hit           = hit_q;
    assign lineCount     = line_count_q;
    assign clear_count   = clear_count_q;
    assign mem.row_addr  = row_addr_s;
    assign mem.row_we    = row_we_s;
    assign mem.row_wdata = row_wdata_s;

endmodule

// File: tb/tb_line_clear_scanner.sv
// Randomized and directed bench for line_clear_scanner against a queue-based compaction model.
module tb_line_clear_scanner;
    localparam int WIDTH  = 10;
    localparam int HEIGHT = 20;
    localparam int AW     = 5;
    localparam logic [WIDTH-1:0] FULL = {WIDTH{1'b1}};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, hit;
    logic [1:0] lineCount;
    logic [2:0] clear_count;

    line_clear_scanner_if #(.WIDTH(WIDTH), .AW(AW)) mem_if ();

    line_clear_scanner #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .lineCount   (lineCount),
        .clear_count (clear_count),
        .mem         (mem_if.master)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] board      [HEIGHT];
    logic [WIDTH-1:0] init_board [HEIGHT];
    logic [WIDTH-1:0] exp_board  [HEIGHT];
    logic             load = 1'b0;
    int               vectors = 0;
    int               miscompares = 0;
    int               done_pulses = 0;
    int               last_cnt = 0;

    // Synchronous board RAM with a bulk-load port for the bench.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < HEIGHT; i++) board[i] <= init_board[i];
        end else if (mem_if.row_we) begin
            board[mem_if.row_addr] <= mem_if.row_wdata;
        end
        mem_if.row_rdata <= board[mem_if.row_addr];
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_board();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic clear_init();
        for (int i = 0; i < HEIGHT; i++) init_board[i] = '0;
    endtask

    task automatic random_init();
        int nfull;
        nfull = 0;
        for (int i = 0; i < HEIGHT; i++) begin
            if ($urandom_range(0, 5) == 0 && nfull < 4) begin
                init_board[i] = FULL;
                nfull++;
            end else begin
                init_board[i] = WIDTH'($urandom_range(0, 1022));
            end
        end
    endtask

    // Model: survivors keep their bottom-up order and stack from row HEIGHT-1; the rest is zero.
    task automatic run_scan(input string tag, input int extra_start);
        logic [WIDTH-1:0] q[$];
        int c, n, busy_cnt, exp_lc;
        c = 0;
        for (int row = HEIGHT - 1; row >= 0; row--) begin
            if (board[row] == FULL) c++;
            else q.push_back(board[row]);
        end
        for (int row = HEIGHT - 1; row >= 0; row--) begin
            if (HEIGHT - 1 - row < q.size()) exp_board[row] = q[HEIGHT - 1 - row];
            else exp_board[row] = '0;
        end
        exp_lc = (c > 3) ? 3 : c;

        @(negedge clk);
        check_eq({tag, ".idle_done"}, 32'(done), 32'd0);
        check_eq({tag, ".idle_hit"}, 32'(hit), 32'd0);
        check_eq({tag, ".idle_lc"}, 32'(lineCount), 32'd0);
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".held_cc"}, 32'(clear_count), 32'(last_cnt));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check_eq({tag, ".busy_rise"}, 32'(busy), 32'd1);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            start = (n == extra_start);
            if (busy === 1'b1) busy_cnt++;
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, 32'(n), 32'(2 * HEIGHT + c + 1));
        check_eq({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(2 * HEIGHT + c));
        check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, ".hit"}, 32'(hit), 32'(c > 0));
        check_eq({tag, ".lineCount"}, 32'(lineCount), 32'(exp_lc));
        check_eq({tag, ".clear_count"}, 32'(clear_count), 32'(c));
        last_cnt = c;
        for (int row = 0; row < HEIGHT; row++) begin
            check_eq($sformatf("%s.row%0d", tag, row), 32'(board[row]), 32'(exp_board[row]));
        end
    endtask

    initial begin
        int dp0;
        clear_init();
        repeat (3) @(negedge clk);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.hit", 32'(hit), 32'd0);
        check_eq("rst.lc", 32'(lineCount), 32'd0);
        check_eq("rst.cc", 32'(clear_count), 32'd0);
        check_eq("rst.we", 32'(mem_if.row_we), 32'd0);
        check_eq("rst.addr", 32'(mem_if.row_addr), 32'd0);
        rst_n = 1'b1;

        load_board();
        run_scan("empty", 0);

        clear_init();
        init_board[19] = 10'h3FF;
        init_board[18] = 10'h001;
        load_board();
        run_scan("single", 0);

        clear_init();
        init_board[19] = 10'h3FF;
        init_board[18] = 10'h155;
        init_board[17] = 10'h3FF;
        init_board[16] = 10'h2AA;
        load_board();
        run_scan("interleave", 0);

        clear_init();
        for (int i = 16; i < 20; i++) init_board[i] = 10'h3FF;
        init_board[15] = 10'h00F;
        load_board();
        run_scan("tetris", 0);
        run_scan("chain", 0);

        random_init();
        init_board[19] = FULL;
        load_board();
        dp0 = done_pulses;
        run_scan("busy_start", 10);
        repeat (50) @(negedge clk);
        check_eq("busy_start.pulses", 32'(done_pulses - dp0), 32'd1);
        check_eq("busy_start.idle", 32'(busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            random_init();
            load_board();
            run_scan($sformatf("rand%0d", k), 0);
        end

        clear_init();
        init_board[19] = FULL;
        load_board();
        run_scan("pre_reset", 0);
        random_init();
        for (int i = 0; i < HEIGHT; i++) if (init_board[i] == FULL) init_board[i] = 10'h0F0;
        load_board();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check_eq("midscan.busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async.busy", 32'(busy), 32'd0);
        check_eq("async.done", 32'(done), 32'd0);
        check_eq("async.hit", 32'(hit), 32'd0);
        check_eq("async.lc", 32'(lineCount), 32'd0);
        check_eq("async.cc", 32'(clear_count), 32'd0);
        check_eq("async.we", 32'(mem_if.row_we), 32'd0);
        check_eq("async.addr", 32'(mem_if.row_addr), 32'd0);
        check_eq("async.wdata", 32'(mem_if.row_wdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst.busy", 32'(busy), 32'd0);
        end
        random_init();
        load_board();
        run_scan("post_reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
